// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream
// Description : Read-side controller for synchronous_fifo. Issues FIFO pops,
//               absorbs the FIFO's one-cycle read latency in a 2-entry skid
//               buffer and presents words on a valid/ready stream. Keeps a
//               wrapping count of delivered words.
// Ports       : clk, rst_n             - clock, async active-low reset
//               fifo_empty             - FIFO empty flag
//               fifo_rd_data           - FIFO read data (cycle after pop)
//               fifo_rd_en             - FIFO pop request
//               flush                  - sync clear of buffer + in-flight read
//               out_valid/out_ready    - output stream handshake
//               out_data               - head of the skid buffer
//               occupancy              - entries held in the buffer (0..2)
//               word_cnt               - delivered words, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_ONE   = 2'd1;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                  r_inflight;   // a pop was issued last cycle
    logic [1:0]            r_occ;        // buffered entries
    logic [DATA_WIDTH-1:0] r_head;       // entry 0, drives out_data
    logic [DATA_WIDTH-1:0] r_tail;       // entry 1
    logic [CNT_WIDTH-1:0]  r_word_cnt;

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic                  w_push;
    logic                  w_pop;
    logic [2:0]            w_committed;
    logic                  w_has_room;
    logic [1:0]            w_occ_nxt;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic [DATA_WIDTH-1:0] w_tail_nxt;

    assign out_valid = (r_occ != c_OCC_EMPTY);
    assign out_data  = r_head;
    assign occupancy = r_occ;
    assign word_cnt  = r_word_cnt;

    assign w_pop  = out_valid && out_ready;
    assign w_push = r_inflight;

    // Entries already buffered plus the word still on its way from the FIFO.
    // A pop in this cycle frees one slot, so a new read may be issued even
    // when the committed total is already two.
    assign w_committed = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_has_room  = (w_committed < 3'd2) || w_pop;

    // Gating with rst_n keeps the FIFO from being popped while this block is
    // held in reset and could not capture the returned word.
    assign fifo_rd_en = rst_n && !fifo_empty && !flush && w_has_room;

    // Skid buffer next-state. Entry 0 is always the oldest word.
    always_comb begin
        w_occ_nxt  = r_occ;
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        if (flush) begin
            // The in-flight return (if any) is dropped along with the buffer.
            w_occ_nxt = c_OCC_EMPTY;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == c_OCC_EMPTY) begin
                        w_head_nxt = fifo_rd_data;
                    end else begin
                        w_tail_nxt = fifo_rd_data;
                    end
                    if (r_occ != c_OCC_FULL) begin
                        w_occ_nxt = r_occ + 2'd1;
                    end
                end
                2'b01: begin
                    w_head_nxt = r_tail;
                    w_occ_nxt  = r_occ - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; with a single entry the new word
                    // replaces the departing head directly.
                    if (r_occ == c_OCC_ONE) begin
                        w_head_nxt = fifo_rd_data;
                    end else begin
                        w_head_nxt = r_tail;
                        w_tail_nxt = fifo_rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_occ      <= c_OCC_EMPTY;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            r_occ      <= w_occ_nxt;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
        end
    end

    // A handshake in a flush cycle still completes, so it is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Checks
    // ------------------------------------------------------------------------
    // The read-issue rule keeps occupancy + inflight <= 2, so a returning
    // word must never find the buffer full with nothing leaving.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_occ == c_OCC_FULL))
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_stream
// Description : Self-checking bench for fifo_rd_stream. A behavioural FIFO
//               feeds the DUT; every word it returns is queued on a
//               scoreboard and matched against stream handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    localparam int c_DW = 8;
    localparam int c_CW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            fifo_empty;
    logic [c_DW-1:0] fifo_rd_data = '0;
    logic            fifo_rd_en;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [c_DW-1:0] out_data;
    logic [1:0]      occupancy;
    logic [c_CW-1:0] word_cnt;

    fifo_rd_stream #(
        .DATA_WIDTH (c_DW),
        .CNT_WIDTH  (c_CW)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .occupancy    (occupancy),
        .word_cnt     (word_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Behavioural FIFO: one-cycle read latency, circular 256-word store
    // ------------------------------------------------------------------------
    logic [c_DW-1:0] mem [0:255];
    int              rd_ptr = 0;
    int              wr_ptr = 0;
    logic [c_DW-1:0] pend [$];     // words returned by the FIFO, not yet delivered

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[rd_ptr[7:0]];
            pend.push_back(mem[rd_ptr[7:0]]);
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int              total = 0;
    int              bad = 0;
    int              rd_pulses = 0;
    int              hs_cnt = 0;
    int              exp_occ;
    logic [c_CW-1:0] cnt_model = '0;
    logic            prev_rd_en = 1'b0;
    logic            prev_stall = 1'b0;
    logic            prev_flush = 1'b0;
    logic [c_DW-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle monitor, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            cnt_model  = '0;
            prev_rd_en = 1'b0;
            prev_stall = 1'b0;
            prev_flush = 1'b0;
        end else begin
            // The word popped last cycle is still in flight, not buffered.
            exp_occ = pend.size() - int'(prev_rd_en);
            chk("occupancy", {30'd0, occupancy}, exp_occ);
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_occ != 0});
            chk("word_cnt", {16'd0, word_cnt}, {16'd0, cnt_model});
            if (flush) begin
                chk("rd_en_in_flush", {31'd0, fifo_rd_en}, 32'd0);
            end
            if (fifo_rd_en) begin
                rd_pulses++;
                chk("rd_en_underflow", {31'd0, fifo_empty}, 32'd0);
                if (exp_occ + int'(prev_rd_en) == 2) begin
                    chk("rd_en_no_room", {31'd0, out_valid && out_ready}, 32'd1);
                end
            end
            if (prev_stall && !prev_flush) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", {24'd0, out_data}, {24'd0, prev_data});
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                cnt_model = cnt_model + 1'b1;
                if (pend.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_data: got 0x%0h expected nothing (scoreboard empty)", out_data);
                end else begin
                    chk("out_data", {24'd0, out_data}, {24'd0, pend.pop_front()});
                end
            end
            if (flush) begin
                pend.delete();
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_flush = flush;
            prev_rd_en = fifo_rd_en;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [c_DW-1:0] v);
        mem[wr_ptr[7:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    typedef struct {
        int         n;            // words loaded
        logic [3:0] pat;          // out_ready pattern, bit 0 first
        int         exp_pulses;   // rd_en pulses
        int         exp_words;    // handshakes
        int         exp_cycles;   // cycles to drain, -1 = not checked
    } vec_t;

    vec_t            vecs [4];
    int              base_p;
    int              base_h;
    int              cyc;
    logic [c_CW-1:0] base_c;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = i[7:0];
        end
        vecs[0] = '{8, 4'b1111, 8, 8, 10};
        vecs[1] = '{8, 4'b1001, 8, 8, -1};
        vecs[2] = '{1, 4'b1111, 1, 1, 3};
        vecs[3] = '{3, 4'b0101, 3, 3, -1};

        // Reset state
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
        chk("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Idle with an empty FIFO
        for (int i = 0; i < 10; i++) tick();
        chk("idle_rd_pulses", rd_pulses, 0);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_word_cnt", {16'd0, word_cnt}, 32'd0);

        // First-word latency
        load(8'h5A);
        #1;
        chk("lat_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        tick();
        chk("lat_valid_c1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("lat_valid_c2", {31'd0, out_valid}, 32'd1);
        chk("lat_data", {24'd0, out_data}, 32'h5A);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("lat_drained", {31'd0, out_valid}, 32'd0);

        // Table-driven bursts
        for (int v = 0; v < 4; v++) begin
            base_p = rd_pulses;
            base_h = hs_cnt;
            base_c = cnt_model;
            for (int k = 0; k < vecs[v].n; k++) load(8'h11 + k[7:0]);
            cyc = 0;
            while ((hs_cnt - base_h) < vecs[v].n && cyc < 200) begin
                out_ready = vecs[v].pat[cyc % 4];
                tick();
                cyc++;
            end
            chk("tbl_timeout", {31'd0, cyc < 200}, 32'd1);
            if (vecs[v].exp_cycles >= 0) begin
                chk("tbl_cycles", cyc, vecs[v].exp_cycles);
            end
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) tick();
            chk("tbl_end_valid", {31'd0, out_valid}, 32'd0);
            chk("tbl_pulses", rd_pulses - base_p, vecs[v].exp_pulses);
            chk("tbl_words", hs_cnt - base_h, vecs[v].exp_words);
            chk("tbl_word_cnt", {16'd0, word_cnt}, {16'd0, base_c + c_CW'(vecs[v].exp_words)});
        end

        // Full backpressure: only two reads may be issued
        base_p = rd_pulses;
        base_h = hs_cnt;
        for (int k = 0; k < 8; k++) load(8'h11 + k[7:0]);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_pulses", rd_pulses - base_p, 2);
        chk("bp_occupancy", {30'd0, occupancy}, 32'd2);
        chk("bp_head", {24'd0, out_data}, 32'h11);
        out_ready = 1'b1;
        cyc = 0;
        while ((hs_cnt - base_h) < 8 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("bp_timeout", {31'd0, cyc < 100}, 32'd1);
        out_ready = 1'b0;
        tick();
        chk("bp_total_pulses", rd_pulses - base_p, 8);

        // Flush with one buffered word and one in flight
        base_p = rd_pulses;
        base_h = hs_cnt;
        for (int k = 0; k < 8; k++) load(8'h21 + k[7:0]);
        for (int i = 0; i < 4; i++) tick();
        chk("fl_pre_occ", {30'd0, occupancy}, 32'd2);
        out_ready = 1'b1;
        tick();
        chk("fl_mid_occ", {30'd0, occupancy}, 32'd1);
        flush = 1'b1;
        #1;
        chk("fl_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_occ_cleared", {30'd0, occupancy}, 32'd0);
        chk("fl_valid_cleared", {31'd0, out_valid}, 32'd0);
        chk("fl_hs_counted", hs_cnt - base_h, 2);
        cyc = 0;
        while ((hs_cnt - base_h) < 7 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("fl_timeout", {31'd0, cyc < 100}, 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("fl_words", hs_cnt - base_h, 7);
        chk("fl_pulses", rd_pulses - base_p, 8);

        // Asynchronous reset mid-stream
        for (int k = 0; k < 8; k++) load(8'h31 + k[7:0]);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_occupancy", {30'd0, occupancy}, 32'd0);
        chk("ar_word_cnt", {16'd0, word_cnt}, 32'd0);
        chk("ar_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("ar_out_data", {24'd0, out_data}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        base_h = hs_cnt;
        cyc = 0;
        while (!(fifo_empty && !out_valid) && cyc < 50) begin
            tick();
            cyc++;
        end
        tick();
        chk("ar_timeout", {31'd0, cyc < 50}, 32'd1);
        chk("ar_post_words", hs_cnt - base_h, 4);

        // Counter wrap: 65537 handshakes from zero
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        base_h = hs_cnt;
        wr_ptr = rd_ptr + 100000;
        out_ready = 1'b1;
        cyc = 0;
        while ((hs_cnt - base_h) < 65537 && cyc < 70000) begin
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        chk("wrap_timeout", {31'd0, cyc < 70000}, 32'd1);
        chk("wrap_word_cnt", {16'd0, word_cnt}, 32'h0001);
        chk("wrap_cycles", cyc, 65537 + 2);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
